// File: rtl/program_loader.sv
// program_loader: streams DEPTH host bytes into program RAM while holding the CPU, then releases it.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before release.
module program_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic [AW-1:0] ram_address,
    output logic [7:0]    ram_data,
    output logic          ram_write_enable,
    output logic          cpu_hold,
    output logic          done,
    output logic          err,
    output logic [AW:0]   byte_count
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

    localparam logic [AW:0] DepthCount = (AW+1)'(DEPTH);
    localparam logic [AW:0] LastCount  = (AW+1)'(DEPTH - 1);

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          we_q, we_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW:0]   count_q, count_d;
    logic          accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    assign accept = in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        err_d   = err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (accept) begin
                    state_d = WRITE;
                    data_d  = in_data;
                    addr_d  = count_q[AW-1:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                end
            end
            WRITE: begin
                // An aborted write never counts as written, so byte_count stays put.
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    count_d = (count_q >= DepthCount) ? DepthCount : count_q + 1'b1;
                    if (count_q >= LastCount) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (accept) begin
                    if (in_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies decoded from the upcoming state.
        ready_d = (state_d == LOAD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (state_d == CHECK) ready_d = 1'b1;
`endif
        we_d   = (state_d == WRITE);
        hold_d = (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Abort outranks the strobe even in the cycle it is already being issued.
    assign ram_write_enable = we_q && !abort;
    assign in_ready         = ready_q;
    assign ram_address      = addr_q;
    assign ram_data         = data_q;
    assign cpu_hold         = hold_q;
    assign done             = done_q;
    assign err              = err_q;
    assign byte_count       = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed sessions with random data and handshake
// patterns, compared against a queue-based model of the bytes that should land in RAM.
module tb_program_loader;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          ram_write_enable;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   byte_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]    txBytes[$];
    logic [AW-1:0] wrAddr[$];
    logic [7:0]    wrData[$];

    program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .ram_address(ram_address),
        .ram_data(ram_data),
        .ram_write_enable(ram_write_enable),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // The RAM as seen by the loader: every strobe sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && ram_write_enable) begin
            wrAddr.push_back(ram_address);
            wrData.push_back(ram_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelSum(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s + txBytes[i];
        return s;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_we"},    32'(ram_write_enable), 32'd0);
        checkOutput({tag, "_addr"},  32'(ram_address), 32'd0);
        checkOutput({tag, "_data"},  32'(ram_data), 32'd0);
        checkOutput({tag, "_hold"},  32'(cpu_hold), 32'd1);
        checkOutput({tag, "_done"},  32'(done), 32'd0);
        checkOutput({tag, "_err"},   32'(err), 32'd0);
        checkOutput({tag, "_count"}, 32'(byte_count), 32'd0);
    endtask

    task automatic startSession();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wrAddr.delete();
        wrData.delete();
    endtask

    // Offers txBytes[first..last-1]; pattern 0 = valid held, 1 = valid toggles every 3 cycles,
    // 2 = random valid plus a stray start pulse. Returns with the DUT just past the last acceptance.
    task automatic applyStimulus(input int pattern, input int first, input int last, output int used);
        int idx = first;
        int cyc = 0;
        int budget = 20 * (last - first) + 20;
        while (idx < last && cyc < budget) begin
            case (pattern)
                0:       in_valid = 1'b1;
                1:       in_valid = ((cyc / 3) % 2) == 0;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            start   = (pattern == 2) && (cyc == 4);
            in_data = txBytes[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        used     = cyc;
        if (idx < last) checkOutput("acceptTimeout", 32'(idx), 32'(last));
    endtask

    task automatic waitEnd(input int budget, output int cyc);
        cyc = 0;
        while (!done && !err && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done && !err) checkOutput("endTimeout", 32'(cyc), 32'(budget));
    endtask

    task automatic completeLoad(input int pattern, output int used, output int tail);
        int extra;
        applyStimulus(pattern, 0, DEPTH, used);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        applyStimulus(pattern, DEPTH, DEPTH + 1, extra);
`else
        extra = 0;
`endif
        waitEnd(8, tail);
        tail = tail + extra;
    endtask

    task automatic checkStrobes(input string tag, input int n);
        checkOutput({tag, "_strobes"}, 32'(wrAddr.size()), 32'(n));
        for (int i = 0; i < n && i < wrAddr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wrAddr[i]), 32'(i));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(wrData[i]), 32'(txBytes[i]));
        end
    endtask

    task automatic randomBytes(input int n);
        txBytes.delete();
        for (int i = 0; i < n; i++) txBytes.push_back(8'($urandom_range(0, 255)));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        txBytes.push_back(modelSum(n));
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int used;
        int tail;

        // Reset state, then idle until start.
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_ready", 32'(in_ready), 32'd0);
        checkOutput("idle_hold",  32'(cpu_hold), 32'd1);
        checkOutput("idle_done",  32'(done), 32'd0);

        // Full back-to-back load of 0x10..0x1F: one byte per two cycles.
        txBytes.delete();
        for (int i = 0; i < DEPTH; i++) txBytes.push_back(8'(8'h10 + i));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        txBytes.push_back(modelSum(DEPTH));
`endif
        startSession();
        checkOutput("A_readyAtLoad", 32'(in_ready), 32'd1);
        checkOutput("A_countAtLoad", 32'(byte_count), 32'd0);
        completeLoad(0, used, tail);
        checkOutput("A_acceptCycles", 32'(used), 32'(2 * DEPTH - 1));
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        checkOutput("A_doneLatency", 32'(tail), 32'd1);
`endif
        checkOutput("A_done",  32'(done), 32'd1);
        checkOutput("A_hold",  32'(cpu_hold), 32'd0);
        checkOutput("A_ready", 32'(in_ready), 32'd0);
        checkOutput("A_count", 32'(byte_count), 32'(DEPTH));
        checkOutput("A_err",   32'(err), 32'd0);
        checkStrobes("A", DEPTH);

        // Reload from DONE with in_valid toggling every three cycles.
        randomBytes(DEPTH);
        startSession();
        checkOutput("B_reloadHold",  32'(cpu_hold), 32'd1);
        checkOutput("B_reloadDone",  32'(done), 32'd0);
        checkOutput("B_reloadCount", 32'(byte_count), 32'd0);
        completeLoad(1, used, tail);
        checkOutput("B_done",  32'(done), 32'd1);
        checkOutput("B_count", 32'(byte_count), 32'(DEPTH));
        checkStrobes("B", DEPTH);

        // Random valid with a stray start mid-session, which must be ignored.
        randomBytes(DEPTH);
        startSession();
        completeLoad(2, used, tail);
        checkOutput("C_done",  32'(done), 32'd1);
        checkOutput("C_count", 32'(byte_count), 32'(DEPTH));
        checkStrobes("C", DEPTH);

        // Abort in DONE is ignored.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("doneAbort_done", 32'(done), 32'd1);
        checkOutput("doneAbort_err",  32'(err), 32'd0);

        // Abort in LOAD after five bytes, with a sixth byte on offer.
        randomBytes(DEPTH);
        startSession();
        applyStimulus(0, 0, 5, used);
        @(posedge clk); #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = txBytes[5];
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("D_err",   32'(err), 32'd1);
        checkOutput("D_hold",  32'(cpu_hold), 32'd1);
        checkOutput("D_count", 32'(byte_count), 32'd5);
        checkOutput("D_ready", 32'(in_ready), 32'd0);
        checkOutput("D_done",  32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkStrobes("D", 5);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("idleAbort_ready", 32'(in_ready), 32'd0);
        checkOutput("idleAbort_err",   32'(err), 32'd1);

        // Abort landing on a WRITE cycle suppresses that strobe.
        randomBytes(DEPTH);
        startSession();
        checkOutput("E_errCleared", 32'(err), 32'd0);
        applyStimulus(0, 0, 3, used);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("E_err",   32'(err), 32'd1);
        checkOutput("E_count", 32'(byte_count), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        checkStrobes("E", 2);

        // Asynchronous reset in the middle of a WRITE.
        randomBytes(DEPTH);
        startSession();
        applyStimulus(0, 0, 2, used);
        @(negedge clk);
        checkOutput("F_weBefore", 32'(ram_write_enable), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        checkResetValues("F_async");
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("F_idleReady", 32'(in_ready), 32'd0);
        checkOutput("F_idleHold",  32'(cpu_hold), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Sixteen 0x01 bytes: trailer 0x10 matches, 0x11 does not.
        txBytes.delete();
        for (int i = 0; i < DEPTH; i++) txBytes.push_back(8'h01);
        txBytes.push_back(8'h10);
        startSession();
        completeLoad(0, used, tail);
        checkOutput("G_done", 32'(done), 32'd1);
        checkOutput("G_err",  32'(err), 32'd0);
        checkStrobes("G", DEPTH);
        txBytes[DEPTH] = 8'h11;
        startSession();
        completeLoad(0, used, tail);
        checkOutput("H_err",  32'(err), 32'd1);
        checkOutput("H_hold", 32'(cpu_hold), 32'd1);
        checkOutput("H_done", 32'(done), 32'd0);
        checkStrobes("H", DEPTH);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of RAM words loaded per session (power of two, 2..16).
REQ-002 Parameter AW, default 4, RAM address width; SHALL satisfy 2**AW >= DEPTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a load session; level, sampled only in IDLE or DONE.
REQ-006 abort  input  1  cancel the current session.
REQ-007 in_valid  input  1  host byte valid.
REQ-008 in_data  input  8  host program byte.
REQ-009 in_ready  output  1  loader can accept a byte this cycle.
REQ-010 ram_address  output  AW  RAM write address.
REQ-011 ram_data  output  8  RAM write data.
REQ-012 ram_write_enable  output  1  one-cycle RAM write strobe.
REQ-013 cpu_hold  output  1  high keeps the CPU in reset/stop until the program is loaded.
REQ-014 done  output  1  program loaded; CPU released.
REQ-015 err  output  1  last session failed (abort or checksum).
REQ-016 byte_count  output  AW+1  bytes written in the current session.

Function
REQ-017 States: IDLE, LOAD, WRITE, CHECK, DONE; all outputs registered.
REQ-018 IDLE: in_ready=0, cpu_hold=1; start=1 -> LOAD, byte_count=0, err cleared.
REQ-019 LOAD: in_ready=1; transfer occurs when in_valid && in_ready; the loader captures in_data into ram_data and ram_address=byte_count, then enters WRITE.
REQ-020 WRITE: lasts exactly one cycle with ram_write_enable=1 and in_ready=0, after which byte_count increments.
REQ-021 After WRITE, byte_count<DEPTH -> LOAD; byte_count==DEPTH -> CHECK if CHECKSUM_EN is defined, else DONE.
REQ-022 Throughput: at most one byte per 2 cycles; a 16-byte load with in_valid held high completes in 32 cycles after entering LOAD.
REQ-023 ram_address and ram_data SHALL remain stable from capture through the end of the write strobe.
REQ-024 DONE: cpu_hold=0, done=1, in_ready=0; start=1 -> LOAD (reload), with cpu_hold=1 and done=0 on the next cycle.
REQ-025 abort=1 in LOAD, WRITE or CHECK -> IDLE next cycle, err=1, cpu_hold=1, no write strobe; any WRITE in progress in that cycle is suppressed.
REQ-026 abort has priority over in_valid, start and the write strobe; abort in IDLE or DONE is ignored.
REQ-027 start while in LOAD, WRITE or CHECK is ignored.
REQ-028 in_valid while in_ready=0 is ignored; no byte is consumed.
REQ-029 byte_count saturates at DEPTH; ram_address never wraps within a session.

Reset
REQ-030 reset_n=0 asynchronously forces IDLE, in_ready=0, ram_write_enable=0, ram_address=0, ram_data=0, cpu_hold=1, done=0, err=0, byte_count=0.
REQ-031 Reset asserted mid-session abandons the session without a write strobe; RAM contents are undefined to the loader.
REQ-032 Following reset release, the block remains in IDLE until start.

Configuration
REQ-033 Macro PROGRAM_LOADER_CHECKSUM_EN, when defined: a running 8-bit sum of accepted bytes (mod 256) is kept; in CHECK, in_ready=1 and the next accepted byte is compared against the sum without being written to RAM.
REQ-034 If PROGRAM_LOADER_CHECKSUM_EN is defined and the checksum matches -> DONE; on mismatch -> IDLE with err=1 and cpu_hold=1.
REQ-035 If PROGRAM_LOADER_CHECKSUM_EN is undefined: no CHECK state and no sum logic; sessions go from the last WRITE directly to DONE.

Verification
REQ-036 Reset, start, then bytes 0x10..0x1F with in_valid held high -> 16 strobes at addresses 0..15 with matching data, done=1 and cpu_hold=0 at cycle 32+1.
REQ-037 in_valid toggling every 3 cycles -> no byte lost or duplicated; byte_count reaches 16.
REQ-038 abort asserted after 5 bytes -> IDLE with err=1, cpu_hold=1, byte_count=5, and no sixth strobe.
REQ-039 With the macro defined, 16 bytes of 0x01 followed by 0x10 -> DONE; followed by 0x11 -> err=1 and cpu_hold=1.
REQ-040 reset_n pulsed low during WRITE -> ram_write_enable drops immediately and all outputs take their REQ-030 values.
REQ-041 start in DONE -> cpu_hold=1 and done=0 the next cycle; a second full load then writes addresses from 0.
